edu_token_collect: RTL
======================

Name: edu_token_collect

Overview:
Sequential token collector at the writer end of the EDU token-row selection path. It accumulates per-diagonal-row token arrivals into a registered row-occupancy vector, which is fed to the lowest-row token selector. It then drains that vector one grant at a time, clearing each row the selector returns as a one-hot. A three-state phase FSM separates collection from drain so set and clear never collide.

Parameters:
NUM_ROWS, 7, number of token rows (NUM_AQROW+NUM_AQCOL-1); default is the 4x4 array.
ROW_W, 3, width of a row index; must satisfy 2^ROW_W >= NUM_ROWS.
CNT_W, 3, width of the token counter; must satisfy 2^CNT_W > NUM_ROWS... (see arithmetic rule: counter holds 0..NUM_ROWS).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  in  1  single-cycle pulse; IDLE→COLLECT.
- collect_done  in  1  single-cycle pulse; COLLECT→DRAIN.
- token_in_valid  in  1  token arrival strobe.
- token_in_row  in  ROW_W  row index of the arriving token.
- token_in_ready  out  1  high only in COLLECT.
- grant_valid  in  1  selector presents a grant.
- grant_onehot  in  NUM_ROWS  one-hot row grant from the selector.
- grant_ready  out  1  high only in DRAIN.
- token_exist_rows  out  NUM_ROWS  registered occupancy vector; drives the selector.
- token_cnt  out  CNT_W  number of set bits in token_exist_rows.
- phase  out  2  0=IDLE, 1=COLLECT, 2=DRAIN.
- drain_done  out  1  single-cycle pulse on DRAIN→IDLE.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (rst=0 at a clock edge): the following outputs are all 0: phase=IDLE, token_exist_rows, token_cnt, drain_done, err, token_in_ready and grant_ready. Reset mid-COLLECT or mid-DRAIN discards all tokens, with no drain_done pulse.
- IDLE:
  - start → COLLECT on the next edge.
  - token_in_valid and grant_valid are ignored and set no error.
  - collect_done is ignored.
- COLLECT:
  - Accept happens when token_in_valid and token_in_ready are both high: bit token_in_row is set, visible the next cycle (1-cycle latency), and token_cnt increments.
  - Duplicate arrival to an already-set row: the vector is unchanged, the count is unchanged, and err is set.
  - Row index >= NUM_ROWS: the token is dropped and err is set.
  - grant_valid is ignored.
  - collect_done → DRAIN. A token accepted in the same cycle as collect_done is still recorded.
  - start is ignored.
- DRAIN:
  - Accept happens when grant_valid and grant_ready are both high.
  - A legal grant has grant_onehot with exactly one bit set, and that bit already set in token_exist_rows. It clears the bit next cycle, and token_cnt decrements.
  - Illegal grant (zero bits, multiple bits, or an unset row): the vector is unchanged and err is set.
  - When token_exist_rows is all-zero at a clock edge in DRAIN, the FSM goes to IDLE and drain_done pulses for exactly 1 cycle. This includes entering DRAIN with an empty vector, which yields drain_done on the first DRAIN cycle's edge.
  - Token arrivals, start and collect_done are ignored.
- err: sticky; cleared only by reset.
- token_cnt:
  - Updated in the same edge as the vector.
  - Saturating logic is not needed: the count cannot exceed NUM_ROWS, because duplicates are rejected.
- All outputs are registered except token_in_ready and grant_ready, which decode phase combinationally.

Test Plan:
1. Reset with rst=0 for 2 cycles → all outputs 0 and phase=0. Assert start with rst=0 → phase stays 0.
2. Fill and drain:
   - start, then tokens to rows 5, 2, 6 and collect_done.
   - Expected after collection: token_exist_rows=7'b1100100 and token_cnt=3.
   - Grants 7'b0000100, then 7'b0100000, then 7'b1000000.
   - Expected: the vector steps through 7'b1100000, 7'b1000000 and 7'b0000000; drain_done pulses once; phase returns to 0; err stays 0.
3. Errors during COLLECT:
   - Duplicate token on row 3 → the vector shows only bit 3, token_cnt=1, err=1.
   - After a fresh reset, token_in_row=7 → the vector stays 0 and err=1.
4. Illegal grants in DRAIN with vector 7'b0000011:
   - grant_onehot=7'b0000110 → the vector is unchanged and err=1.
   - grant_onehot=7'b0010000 → the vector is unchanged.
   - Legal grants 7'b0000001 then 7'b0000010 → drain_done.
5. Boundary cases:
   - collect_done in the same cycle as a token to row 0 → phase=2 and bit 0 set.
   - collect_done with no tokens → drain_done one cycle after entering DRAIN.
6. Reset mid-DRAIN with vector 7'b0101010 → the vector is 0 and phase=0 next cycle, with no drain_done pulse.

Source files
------------

// File: rtl/edu_token_collect_if.sv
// Handshake and status bundle between the token collector, its token source
// and the lowest-row token selector.
interface edu_token_collect_if #(
    parameter int NUM_ROWS = 7,
    parameter int ROW_W    = 3,
    parameter int CNT_W    = 3
);
    logic                start;
    logic                collect_done;
    logic                token_in_valid;
    logic [ROW_W-1:0]    token_in_row;
    logic                token_in_ready;
    logic                grant_valid;
    logic [NUM_ROWS-1:0] grant_onehot;
    logic                grant_ready;
    logic [NUM_ROWS-1:0] token_exist_rows;
    logic [CNT_W-1:0]    token_cnt;
    logic [1:0]          phase;
    logic                drain_done;
    logic                err;

    modport master (
        output start, collect_done, token_in_valid, token_in_row,
        output grant_valid, grant_onehot,
        input  token_in_ready, grant_ready, token_exist_rows, token_cnt,
        input  phase, drain_done, err
    );

    modport slave (
        input  start, collect_done, token_in_valid, token_in_row,
        input  grant_valid, grant_onehot,
        output token_in_ready, grant_ready, token_exist_rows, token_cnt,
        output phase, drain_done, err
    );
endinterface

// File: rtl/edu_token_collect.sv
// Collects per-row token arrivals into an occupancy vector, then drains it one
// selector grant at a time; phases keep set and clear from ever colliding.
module edu_token_collect #(
    parameter int NUM_ROWS = 7,
    parameter int ROW_W    = 3,
    parameter int CNT_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    edu_token_collect_if.slave bus
);
    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_COLLECT = 2'd1,
        PH_DRAIN   = 2'd2
    } phase_e;

    phase_e              phase_q, phase_d;
    logic [NUM_ROWS-1:0] rows_q, rows_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                drain_done_q, drain_done_d;

    logic [NUM_ROWS-1:0] set_mask;
    logic                row_in_range;
    logic                row_dup;
    logic                grant_single;
    logic                grant_held;

    // Row decode: an out-of-range index matches no row, so the mask stays zero.
    generate
        for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row_dec
            assign set_mask[gi] = (bus.token_in_row == ROW_W'(gi));
        end
    endgenerate

    assign row_in_range = |set_mask;
    assign row_dup      = |(set_mask & rows_q);
    assign grant_single = (|bus.grant_onehot) &&
                          ((bus.grant_onehot & (bus.grant_onehot - NUM_ROWS'(1))) == '0);
    assign grant_held   = (bus.grant_onehot & ~rows_q) == '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q      <= PH_IDLE;
            rows_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            rows_q       <= rows_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            drain_done_q <= drain_done_d;
        end
    end

    always_comb begin
        phase_d      = phase_q;
        rows_d       = rows_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        drain_done_d = 1'b0;
        unique case (phase_q)
            PH_IDLE: begin
                if (bus.start) phase_d = PH_COLLECT;
            end
            PH_COLLECT: begin
                if (bus.token_in_valid) begin
                    if (!row_in_range || row_dup) begin
                        err_d = 1'b1;
                    end else begin
                        rows_d = rows_q | set_mask;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
                if (bus.collect_done) phase_d = PH_DRAIN;
            end
            PH_DRAIN: begin
                // An empty vector ends the drain even on the first DRAIN cycle.
                if (rows_q == '0) begin
                    phase_d      = PH_IDLE;
                    drain_done_d = 1'b1;
                end else if (bus.grant_valid) begin
                    if (grant_single && grant_held) begin
                        rows_d = rows_q & ~bus.grant_onehot;
                        cnt_d  = cnt_q - CNT_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    assign bus.token_in_ready   = (phase_q == PH_COLLECT);
    assign bus.grant_ready      = (phase_q == PH_DRAIN);
    assign bus.token_exist_rows = rows_q;
    assign bus.token_cnt        = cnt_q;
    assign bus.phase            = phase_q;
    assign bus.drain_done       = drain_done_q;
    assign bus.err              = err_q;
endmodule
